// File: rtl/simple_processor_pkg.sv
// Shared types and helpers for the simple processor pipeline.
// Holds operand width, operation encodings and the issue bundle.
package simple_processor_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int REG_AW     = 5;

    typedef enum logic [1:0] {
        ADD  = 2'd0,
        ADDI = 2'd1,
        SUB  = 2'd2,
        NOP  = 2'd3
    } func_t;

    typedef struct packed {
        func_t                 func;
        logic [REG_AW-1:0]     rd;
        logic [5:0]            imm;
        logic [DATA_WIDTH-1:0] rs1_data;
        logic [DATA_WIDTH-1:0] rs2_data;
    } ex_op_t;

    function automatic logic uses_rs2(func_t f);
        return (f == ADD) || (f == SUB);
    endfunction

    function automatic logic writes_rd(func_t f);
        return (f == ADD) || (f == ADDI) || (f == SUB);
    endfunction

endpackage

// File: rtl/reg_file.sv
// Architectural register file, r0 hardwired to zero.
// Two read ports forward same-cycle writeback data.
module reg_file
    import simple_processor_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int AW       = $clog2(NUM_REGS)
) (
    input  logic                  clk_i,
    input  logic                  arst_ni,
    input  logic                  we_i,
    input  logic [AW-1:0]         waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]         raddr_a_i,
    output logic [DATA_WIDTH-1:0] rdata_a_o,
    input  logic [AW-1:0]         raddr_b_i,
    output logic [DATA_WIDTH-1:0] rdata_b_o
);

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

    logic wr_hit;
    assign wr_hit = we_i && (waddr_i != '0);

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (wr_hit) begin
            regs_d[waddr_i] = wdata_i;
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    always_comb begin
        rdata_a_o = regs_q[raddr_a_i];
        if (raddr_a_i == '0) begin
            rdata_a_o = '0;
        end else if (wr_hit && (waddr_i == raddr_a_i)) begin
            rdata_a_o = wdata_i;
        end
    end

    always_comb begin
        rdata_b_o = regs_q[raddr_b_i];
        if (raddr_b_i == '0) begin
            rdata_b_o = '0;
        end else if (wr_hit && (waddr_i == raddr_b_i)) begin
            rdata_b_o = wdata_i;
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch / issue stage: regfile read, scoreboard
// hazard stall and registered launch toward the ALU.
module operand_fetch
    import simple_processor_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int AW       = $clog2(NUM_REGS)
) (
    input  logic                  clk_i,
    input  logic                  arst_ni,
    input  logic                  instr_valid_i,
    output logic                  instr_ready_o,
    input  func_t                 instr_func_i,
    input  logic [AW-1:0]         instr_rd_i,
    input  logic [AW-1:0]         instr_rs1_i,
    input  logic [AW-1:0]         instr_rs2_i,
    input  logic [5:0]            instr_imm_i,
    output logic                  ex_valid_o,
    input  logic                  ex_ready_i,
    output func_t                 ex_func_o,
    output logic [AW-1:0]         ex_rd_o,
    output logic [5:0]            ex_imm_o,
    output logic [DATA_WIDTH-1:0] ex_rs1_data_o,
    output logic [DATA_WIDTH-1:0] ex_rs2_data_o,
    input  logic                  wb_en_i,
    input  logic [AW-1:0]         wb_addr_i,
    input  logic [DATA_WIDTH-1:0] wb_data_i
);

    logic [DATA_WIDTH-1:0] rs1_data;
    logic [DATA_WIDTH-1:0] rs2_data;

    reg_file #(
        .NUM_REGS (NUM_REGS),
        .AW       (AW)
    ) u_reg_file (
        .clk_i     (clk_i),
        .arst_ni   (arst_ni),
        .we_i      (wb_en_i),
        .waddr_i   (wb_addr_i),
        .wdata_i   (wb_data_i),
        .raddr_a_i (instr_rs1_i),
        .rdata_a_o (rs1_data),
        .raddr_b_i (instr_rs2_i),
        .rdata_b_o (rs2_data)
    );

    logic [NUM_REGS-1:0] pending_q, pending_d;
    logic [NUM_REGS-1:0] clr_vec, pend_eff;
    logic                ex_valid_q, ex_valid_d;
    ex_op_t              ex_q, ex_d;
    logic                wr_rd, hazard, issue;

    always_comb begin
        clr_vec = '0;
        if (wb_en_i) begin
            clr_vec[wb_addr_i] = 1'b1;
        end
        pend_eff = pending_q & ~clr_vec;

        wr_rd = writes_rd(instr_func_i) && (instr_rd_i != '0);

        hazard = instr_valid_i && (pend_eff[instr_rs1_i]
            || (uses_rs2(instr_func_i) && pend_eff[instr_rs2_i])
            || (wr_rd && pend_eff[instr_rd_i]));

        instr_ready_o = (!ex_valid_q || ex_ready_i) && !hazard;
        issue = instr_valid_i && instr_ready_o;

        // A same-cycle issue re-sets a bit the writeback clears.
        pending_d = pend_eff;
        if (issue && wr_rd) begin
            pending_d[instr_rd_i] = 1'b1;
        end
        pending_d[0] = 1'b0;

        ex_valid_d = ex_valid_q;
        ex_d       = ex_q;
        if (issue) begin
            ex_valid_d    = 1'b1;
            ex_d.func     = instr_func_i;
            ex_d.rd       = REG_AW'(instr_rd_i);
            ex_d.imm      = instr_imm_i;
            ex_d.rs1_data = rs1_data;
            ex_d.rs2_data = rs2_data;
        end else if (ex_ready_i) begin
            ex_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            pending_q  <= '0;
            ex_valid_q <= 1'b0;
            ex_q       <= '0;
        end else begin
            pending_q  <= pending_d;
            ex_valid_q <= ex_valid_d;
            ex_q       <= ex_d;
        end
    end

    assign ex_valid_o    = ex_valid_q;
    assign ex_func_o     = ex_q.func;
    assign ex_rd_o       = AW'(ex_q.rd);
    assign ex_imm_o      = ex_q.imm;
    assign ex_rs1_data_o = ex_q.rs1_data;
    assign ex_rs2_data_o = ex_q.rs2_data;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed and random bench for operand_fetch against
// an array-based reference model of regfile, scoreboard and ex slot.
module tb_operand_fetch;
    import simple_processor_pkg::*;

    localparam int N  = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          arst_ni;
    logic          instr_valid_i;
    logic          instr_ready_o;
    func_t         instr_func_i;
    logic [AW-1:0] instr_rd_i, instr_rs1_i, instr_rs2_i;
    logic [5:0]    instr_imm_i;
    logic          ex_valid_o;
    logic          ex_ready_i;
    func_t         ex_func_o;
    logic [AW-1:0] ex_rd_o;
    logic [5:0]    ex_imm_o;
    logic [31:0]   ex_rs1_data_o, ex_rs2_data_o;
    logic          wb_en_i;
    logic [AW-1:0] wb_addr_i;
    logic [31:0]   wb_data_i;

    operand_fetch #(.NUM_REGS(N)) dut (
        .clk_i         (clk),
        .arst_ni       (arst_ni),
        .instr_valid_i (instr_valid_i),
        .instr_ready_o (instr_ready_o),
        .instr_func_i  (instr_func_i),
        .instr_rd_i    (instr_rd_i),
        .instr_rs1_i   (instr_rs1_i),
        .instr_rs2_i   (instr_rs2_i),
        .instr_imm_i   (instr_imm_i),
        .ex_valid_o    (ex_valid_o),
        .ex_ready_i    (ex_ready_i),
        .ex_func_o     (ex_func_o),
        .ex_rd_o       (ex_rd_o),
        .ex_imm_o      (ex_imm_o),
        .ex_rs1_data_o (ex_rs1_data_o),
        .ex_rs2_data_o (ex_rs2_data_o),
        .wb_en_i       (wb_en_i),
        .wb_addr_i     (wb_addr_i),
        .wb_data_i     (wb_data_i)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_regs [N];
    bit          m_pend [N];
    bit          m_exv;
    func_t       m_func;
    logic [4:0]  m_rd;
    logic [5:0]  m_imm;
    logic [31:0] m_rs1, m_rs2;

    task automatic chk(string tag, logic [31:0] obs,
                       logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h",
                   tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_regs[i] = 0;
            m_pend[i] = 0;
        end
        m_exv = 0; m_func = ADD; m_rd = 0;
        m_imm = 0; m_rs1 = 0; m_rs2 = 0;
    endtask

    function automatic logic [31:0] m_read(logic [4:0] r);
        if (r == 0) return 0;
        if (wb_en_i && wb_addr_i == r) return wb_data_i;
        return m_regs[r];
    endfunction

    function automatic bit m_busy(logic [4:0] r);
        return m_pend[r] && !(wb_en_i && wb_addr_i == r);
    endfunction

    function automatic bit m_writes();
        return (instr_func_i inside {ADD, ADDI, SUB})
            && instr_rd_i != 0;
    endfunction

    function automatic bit m_ready();
        bit hz;
        hz = instr_valid_i && (m_busy(instr_rs1_i)
            || ((instr_func_i inside {ADD, SUB})
                && m_busy(instr_rs2_i))
            || (m_writes() && m_busy(instr_rd_i)));
        return (!m_exv || ex_ready_i) && !hz;
    endfunction

    task automatic check_outputs(string tag);
        chk({tag, ".ready"}, 32'(instr_ready_o), 32'(m_ready()));
        chk({tag, ".exv"}, 32'(ex_valid_o), 32'(m_exv));
        chk({tag, ".func"}, 32'(ex_func_o), 32'(m_func));
        chk({tag, ".rd"}, 32'(ex_rd_o), 32'(m_rd));
        chk({tag, ".imm"}, 32'(ex_imm_o), 32'(m_imm));
        chk({tag, ".rs1"}, ex_rs1_data_o, m_rs1);
        chk({tag, ".rs2"}, ex_rs2_data_o, m_rs2);
    endtask

    // Checks the current cycle, then advances one clock edge.
    task automatic step(string tag);
        bit          iss, wr;
        logic [31:0] a, b;
        #1;
        check_outputs(tag);
        iss = instr_valid_i && m_ready();
        wr  = m_writes();
        a   = m_read(instr_rs1_i);
        b   = m_read(instr_rs2_i);
        @(posedge clk);
        if (wb_en_i) m_pend[wb_addr_i] = 0;
        if (wb_en_i && wb_addr_i != 0)
            m_regs[wb_addr_i] = wb_data_i;
        if (iss) begin
            if (wr) m_pend[instr_rd_i] = 1;
            m_exv = 1; m_func = instr_func_i;
            m_rd = instr_rd_i; m_imm = instr_imm_i;
            m_rs1 = a; m_rs2 = b;
        end else if (ex_ready_i) begin
            m_exv = 0;
        end
        #1;
    endtask

    task automatic instr(bit v, func_t f, int rd, int r1,
                         int r2, int imm);
        instr_valid_i = v; instr_func_i = f;
        instr_rd_i = AW'(rd); instr_rs1_i = AW'(r1);
        instr_rs2_i = AW'(r2); instr_imm_i = 6'(imm);
    endtask

    task automatic wb(bit en, int a, logic [31:0] d);
        wb_en_i = en; wb_addr_i = AW'(a); wb_data_i = d;
    endtask

    logic [31:0] rnd;

    initial begin
        arst_ni = 0; ex_ready_i = 1;
        instr(0, ADD, 0, 0, 0, 0);
        wb(0, 0, 0);
        model_reset();
        #12 arst_ni = 1;
        @(posedge clk); #1;

        #1;
        chk("rst.exv", 32'(ex_valid_o), 0);
        chk("rst.ready", 32'(instr_ready_o), 1);
        chk("rst.rs1", ex_rs1_data_o, 0);
        step("rst");

        wb(1, 3, 32'h5);
        step("wb_r3");
        wb(0, 0, 0);
        instr(1, ADD, 4, 3, 0, 7);
        step("add_r4");
        chk("add.exv", 32'(ex_valid_o), 1);
        chk("add.rs1", ex_rs1_data_o, 32'h5);
        chk("add.rs2", ex_rs2_data_o, 0);
        chk("add.imm", 32'(ex_imm_o), 7);

        instr(1, ADDI, 5, 4, 0, 3);
        #1 chk("raw.stall", 32'(instr_ready_o), 0);
        step("raw_stall");
        wb(1, 4, 32'hFFFF_FFFE);
        #1 chk("raw.bypass_rdy", 32'(instr_ready_o), 1);
        step("raw_go");
        wb(0, 0, 0);
        chk("raw.rs1", ex_rs1_data_o, 32'hFFFF_FFFE);

        instr(1, ADD, 6, 3, 4, 1);
        ex_ready_i = 0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("exstall.rdy", 32'(instr_ready_o), 0);
            step("exstall");
            chk("exstall.rs1", ex_rs1_data_o, 32'hFFFF_FFFE);
        end
        ex_ready_i = 1;
        step("b2b_a");
        chk("b2b.rs1", ex_rs1_data_o, 32'h5);
        instr(1, ADD, 8, 3, 3, 2);
        #1 chk("b2b.rdy", 32'(instr_ready_o), 1);
        step("b2b_b");

        instr(1, SUB, 0, 0, 0, 0);
        wb(1, 0, 32'hDEAD_BEEF);
        step("r0");
        wb(0, 0, 0);
        instr(0, ADD, 0, 0, 0, 0);
        chk("r0.rs1", ex_rs1_data_o, 0);
        chk("r0.rs2", ex_rs2_data_o, 0);

        wb(1, 5, 32'h55); step("clr5");
        wb(1, 6, 32'h66); step("clr6");
        wb(1, 8, 32'h88); step("clr8");
        instr(1, ADD, 7, 5, 6, 0);
        wb(1, 7, 32'h77);
        step("setwins");
        wb(0, 0, 0);
        instr(1, SUB, 9, 5, 7, 0);
        #1 chk("setwins.stall", 32'(instr_ready_o), 0);
        step("sw_stall1");
        step("sw_stall2");
        wb(1, 7, 32'h1234_5678);
        step("sw_go");
        wb(0, 0, 0);
        chk("sw.rs2", ex_rs2_data_o, 32'h1234_5678);

        instr(1, ADD, 10, 5, 6, 0);
        ex_ready_i = 0;
        step("pre_rst");
        chk("pre_rst.exv", 32'(ex_valid_o), 1);
        arst_ni = 0;
        #1 chk("arst.exv", 32'(ex_valid_o), 0);
        chk("arst.rs1", ex_rs1_data_o, 0);
        model_reset();
        #1 arst_ni = 1;
        ex_ready_i = 1;
        instr(1, ADD, 11, 10, 5, 0);
        #1 chk("arst.rdy", 32'(instr_ready_o), 1);
        step("post_rst");
        chk("post.rs1", ex_rs1_data_o, 0);
        chk("post.rs2", ex_rs2_data_o, 0);

        for (int c = 0; c < 600; c++) begin
            rnd = $urandom;
            instr(rnd[0], func_t'(rnd[2:1]), int'(rnd[7:3]),
                  int'(rnd[12:8]), int'(rnd[17:13]),
                  int'(rnd[23:18]));
            ex_ready_i = (rnd[26:24] != 0);
            wb(rnd[27], $urandom_range(0, N - 1), $urandom);
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
